// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and FSM types for the issue-stage register scoreboard.
package reg_scoreboard_pkg;
  localparam int NUM_REGS     = 32;
  localparam int NUM_ISSUE_CH = 2;
  localparam int NUM_WB_PORTS = 2;

  typedef enum logic {SB_RUN, SB_BLOCKED} sb_state_e;
endpackage

// File: rtl/reg_scoreboard_sb_chan_ckr.sv
// Combinational hazard check for one issue channel. Channels are chained
// through prev_req so a younger channel can only request behind an older one.
module reg_scoreboard_sb_chan_ckr
  import reg_scoreboard_pkg::*;
#(
  parameter int NR    = NUM_REGS,
  parameter bit FIRST = 1'b0,
  localparam int RW   = $clog2(NR)
) (
  input  logic          run,
  input  logic          valid,
  input  logic          blocking,
  input  logic [RW-1:0] rd,
  input  logic [NR-1:0] reg_req,
  input  logic          mem_op,
  input  logic [NR-1:0] locks,
  input  logic          mem_busy,
  input  logic [NR-1:0] older_rd,
  input  logic          older_mem,
  input  logic          prev_req,
  output logic          req
);
  // x0 never participates in any hazard
  localparam logic [NR-1:0] SRC_MASK = {{(NR-1){1'b1}}, 1'b0};

  logic [NR-1:0] rd_oh;
  logic raw, waw, bundle_hz, mem_hz, blk_hz;

  assign rd_oh     = {{(NR-1){1'b0}}, 1'b1} << rd;
  assign raw       = |(reg_req & locks & SRC_MASK);
  assign waw       = |(rd_oh & locks & SRC_MASK);
  assign bundle_hz = |((reg_req | rd_oh) & older_rd & SRC_MASK);
  assign mem_hz    = mem_op & (mem_busy | older_mem);
  // serialising instructions only issue alone from the oldest slot on a quiet machine
  assign blk_hz    = blocking & (!FIRST || (|locks) || mem_busy);

  assign req = run & valid & prev_req & ~raw & ~waw & ~bundle_hz & ~mem_hz & ~blk_hz;
endmodule

// File: rtl/reg_scoreboard.sv
// Multi-channel register scoreboard: holds register locks, memory-busy and
// serialising state, and produces in-order per-channel issue requests.
//   state      | meaning
//   SB_RUN     | normal issue, requests evaluated per channel
//   SB_BLOCKED | serialising instruction in flight, no issue until blk_done_i
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NR   = NUM_REGS,
  parameter int NCH  = NUM_ISSUE_CH,
  parameter int NWB  = NUM_WB_PORTS,
  localparam int RW  = $clog2(NR)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NCH-1:0]           pl_valid_i,
  input  logic [NCH-1:0]           blocking_i,
  input  logic [NCH-1:0][RW-1:0]   rd_i,
  input  logic [NCH-1:0][NR-1:0]   reg_req_i,
  input  logic [NCH-1:0]           mem_op_i,
  input  logic [NCH-1:0]           gnt_i,
  input  logic [NWB-1:0]           wb_valid_i,
  input  logic [NWB-1:0][RW-1:0]   wb_rd_i,
  input  logic                     mem_done_i,
  input  logic                     blk_done_i,
  output logic [NCH-1:0]           arb_req_o,
  output logic [NR-1:0]            locks_o,
  output logic                     mem_busy_o,
  output logic                     blocked_o
);
  sb_state_e     state_q;
  logic [NR-1:0] locks_q, locks_d, lock_set, lock_clr;
  logic          mem_busy_q;
  logic          run;
  logic [NCH-1:0] qual;
  logic [NR-1:0] older_rd [NCH];
  logic [NCH-1:0] older_mem;

  assign run  = (state_q == SB_RUN);
  assign qual = gnt_i & arb_req_o;

  always_comb begin : bundle_scan
    logic [NR-1:0] acc;
    logic          accm;
    acc  = '0;
    accm = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      older_rd[k]  = acc;
      older_mem[k] = accm;
      acc[rd_i[k]] = 1'b1;
      accm         = accm | mem_op_i[k];
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic prev, req;
    if (k == 0) begin : g_head
      assign prev = 1'b1;
    end else begin : g_tail
      assign prev = g_ch[k-1].req;
    end
    reg_scoreboard_sb_chan_ckr #(.NR(NR), .FIRST(k == 0)) u_ckr (
      .run       (run),
      .valid     (pl_valid_i[k]),
      .blocking  (blocking_i[k]),
      .rd        (rd_i[k]),
      .reg_req   (reg_req_i[k]),
      .mem_op    (mem_op_i[k]),
      .locks     (locks_q),
      .mem_busy  (mem_busy_q),
      .older_rd  (older_rd[k]),
      .older_mem (older_mem[k]),
      .prev_req  (prev),
      .req       (req)
    );
    assign arb_req_o[k] = req;
  end

  // a new writer's set overrides a same-cycle writeback of the old value
  always_comb begin
    lock_set = '0;
    lock_clr = '0;
    for (int n = 0; n < NWB; n++)
      if (wb_valid_i[n]) lock_clr[wb_rd_i[n]] = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (qual[k]) lock_set[rd_i[k]] = 1'b1;
    locks_d    = (locks_q & ~lock_clr) | lock_set;
    locks_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SB_RUN;
      locks_q    <= '0;
      mem_busy_q <= 1'b0;
    end else begin
      locks_q    <= locks_d;
      mem_busy_q <= (mem_busy_q & ~mem_done_i) | (|(qual & mem_op_i));
      case (state_q)
        SB_RUN:     if (|(qual & blocking_i)) state_q <= SB_BLOCKED;
        SB_BLOCKED: if (blk_done_i) state_q <= SB_RUN;
      endcase
    end
  end

  assign locks_o    = run ? locks_q : {{(NR-1){1'b1}}, 1'b0};
  assign mem_busy_o = mem_busy_q;
  assign blocked_o  = ~run;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios then a random soak,
// expected outputs come from a per-register behavioural model.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic [1:0]       pl_valid, blocking, mem_op, gnt, wb_valid;
  logic [1:0][4:0]  rd, wb_rd;
  logic [1:0][31:0] reg_req;
  logic             mem_done, blk_done;
  logic [1:0]       arb_req;
  logic [31:0]      locks;
  logic             mem_busy, blocked;

  reg_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .pl_valid_i(pl_valid), .blocking_i(blocking),
    .rd_i(rd), .reg_req_i(reg_req), .mem_op_i(mem_op), .gnt_i(gnt),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .mem_done_i(mem_done),
    .blk_done_i(blk_done), .arb_req_o(arb_req), .locks_o(locks),
    .mem_busy_o(mem_busy), .blocked_o(blocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  arb;
    logic [31:0] lk;
    logic        mb;
    logic        blk;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  bit m_lock [32];
  bit m_mb  = 1'b0;
  bit m_blk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic idle();
    rst = 1'b0; pl_valid = '0; blocking = '0; mem_op = '0; gnt = '0;
    wb_valid = '0; rd = '0; wb_rd = '0; reg_req = '0; mem_done = 1'b0; blk_done = 1'b0;
  endtask

  function automatic logic [1:0] model_arb();
    logic [1:0] r;
    bit any_lock, ok;
    r = '0;
    any_lock = 1'b0;
    for (int i = 1; i < 32; i++) if (m_lock[i]) any_lock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ok = !m_blk && pl_valid[k];
      for (int i = 1; i < 32; i++) if (reg_req[k][i] && m_lock[i]) ok = 1'b0;
      if (rd[k] != 0 && m_lock[rd[k]]) ok = 1'b0;
      if (mem_op[k] && m_mb) ok = 1'b0;
      if (blocking[k] && (k != 0 || any_lock || m_mb)) ok = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (!r[j]) ok = 1'b0;
        if (rd[j] != 0 && (reg_req[k][rd[j]] || rd[k] == rd[j])) ok = 1'b0;
        if (mem_op[j] && mem_op[k]) ok = 1'b0;
      end
      r[k] = ok;
    end
    return r;
  endfunction

  // Record this cycle's expected outputs, then advance the model past the next edge.
  task automatic commit();
    exp_t e;
    logic [1:0] q;
    bit nl [32];
    e.arb = model_arb();
    e.lk  = '0;
    for (int i = 0; i < 32; i++) e.lk[i] = m_blk ? (i != 0) : m_lock[i];
    e.mb  = m_mb;
    e.blk = m_blk;
    exp_q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_lock[i] = 1'b0;
      m_mb = 1'b0;
      m_blk = 1'b0;
    end else begin
      q = gnt & e.arb;
      nl = m_lock;
      for (int n = 0; n < 2; n++) if (wb_valid[n] && wb_rd[n] != 0) nl[wb_rd[n]] = 1'b0;
      for (int k = 0; k < 2; k++) if (q[k] && rd[k] != 0) nl[rd[k]] = 1'b1;
      m_lock = nl;
      m_mb = (m_mb && !mem_done) || (q[0] && mem_op[0]) || (q[1] && mem_op[1]);
      if (m_blk) m_blk = !blk_done;
      else       m_blk = ((q & blocking) != 0);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("arb_req", 32'(arb_req), 32'(e.arb));
        check("locks_o", locks, e.lk);
        check("mem_busy", 32'(mem_busy), 32'(e.mb));
        check("blocked", 32'(blocked), 32'(e.blk));
        for (int k = 0; k < 2; k++)
          if (gnt[k] && arb_req[k] && !rst)
            check("grant_src_unlocked", reg_req[k] & locks & 32'hFFFF_FFFE, 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk); idle(); rst = 1'b1; commit();
    @(negedge clk); idle(); commit(); #3;
    check("rst_locks", locks, 32'h0);
    check("rst_blocked", 32'(blocked), 32'h0);
    check("rst_arb", 32'(arb_req), 32'h0);

    // lock latency, no writeback bypass
    @(negedge clk); idle(); pl_valid = 2'b01; rd[0] = 5'd5; gnt = 2'b01; commit(); #3;
    check("lat_req_t0", 32'(arb_req), 32'h1);
    @(negedge clk); idle(); pl_valid = 2'b01; reg_req[0] = 32'h20; commit(); #3;
    check("lat_raw_t1", 32'(arb_req), 32'h0);
    check("lat_lock5", 32'(locks[5]), 32'h1);
    @(negedge clk); idle(); pl_valid = 2'b01; reg_req[0] = 32'h20;
    wb_valid = 2'b01; wb_rd[0] = 5'd5; commit(); #3;
    check("lat_nobypass", 32'(arb_req), 32'h0);
    @(negedge clk); idle(); pl_valid = 2'b01; reg_req[0] = 32'h20; commit(); #3;
    check("lat_release", 32'(arb_req), 32'h1);

    // set wins over same-cycle writeback
    @(negedge clk); idle(); pl_valid = 2'b01; rd[0] = 5'd7; gnt = 2'b01;
    wb_valid = 2'b01; wb_rd[0] = 5'd7; commit();
    @(negedge clk); idle(); wb_valid = 2'b01; wb_rd[0] = 5'd7; commit(); #3;
    check("set_wins", 32'(locks[7]), 32'h1);
    @(negedge clk); idle(); commit(); #3;
    check("wb_clear", locks, 32'h0);

    // intra-bundle hazards and in-order issue
    @(negedge clk); idle(); pl_valid = 2'b11; rd[0] = 5'd3; reg_req[1] = 32'h8; commit(); #3;
    check("bundle_raw", 32'(arb_req), 32'h1);
    @(negedge clk); idle(); pl_valid = 2'b11; rd[0] = 5'd3; reg_req[1] = 32'h200; commit(); #3;
    check("bundle_indep", 32'(arb_req), 32'h3);
    @(negedge clk); idle(); pl_valid = 2'b10; rd[0] = 5'd3; reg_req[1] = 32'h200; commit(); #3;
    check("bundle_inorder", 32'(arb_req), 32'h0);

    // memory busy
    @(negedge clk); idle(); pl_valid = 2'b01; mem_op = 2'b01; gnt = 2'b01; commit();
    @(negedge clk); idle(); pl_valid = 2'b01; mem_op = 2'b01; commit(); #3;
    check("mem_busy_set", 32'(mem_busy), 32'h1);
    check("mem_stall", 32'(arb_req), 32'h0);
    @(negedge clk); idle(); mem_done = 1'b1; commit();
    @(negedge clk); idle(); pl_valid = 2'b01; mem_op = 2'b01; gnt = 2'b01; mem_done = 1'b1; commit(); #3;
    check("mem_free_req", 32'(arb_req), 32'h1);
    @(negedge clk); idle(); commit(); #3;
    check("mem_done_and_grant", 32'(mem_busy), 32'h1);
    @(negedge clk); idle(); mem_done = 1'b1; commit();

    // blocking instruction, then reset mid-BLOCKED
    @(negedge clk); idle(); pl_valid = 2'b01; rd[0] = 5'd2; gnt = 2'b01; commit();
    @(negedge clk); idle(); pl_valid = 2'b01; blocking = 2'b01;
    wb_valid = 2'b01; wb_rd[0] = 5'd2; commit(); #3;
    check("blk_locked_noreq", 32'(arb_req), 32'h0);
    @(negedge clk); idle(); pl_valid = 2'b11; blocking = 2'b01; rd[0] = 5'd4; rd[1] = 5'd5;
    mem_op = 2'b10; gnt = 2'b11; commit(); #3;
    check("blk_req", 32'(arb_req), 32'h3);
    @(negedge clk); idle(); pl_valid = 2'b01; commit(); #3;
    check("blk_state", 32'(blocked), 32'h1);
    check("blk_locks_view", locks, 32'hFFFF_FFFE);
    check("blk_arb", 32'(arb_req), 32'h0);
    @(negedge clk); idle(); wb_valid = 2'b01; wb_rd[0] = 5'd4; commit();
    @(negedge clk); idle(); rst = 1'b1; blk_done = 1'b1; commit();
    @(negedge clk); idle(); commit(); #3;
    check("rst_mid_blk_locks", locks, 32'h0);
    check("rst_mid_blk_state", 32'(blocked), 32'h0);
    check("rst_mid_blk_mem", 32'(mem_busy), 32'h0);

    // blocking round trip through blk_done
    @(negedge clk); idle(); pl_valid = 2'b01; blocking = 2'b01; gnt = 2'b01; commit();
    @(negedge clk); idle(); commit(); #3;
    check("blk_enter", 32'(blocked), 32'h1);
    @(negedge clk); idle(); blk_done = 1'b1; commit();
    @(negedge clk); idle(); blk_done = 1'b1; commit(); #3;
    check("blk_exit", 32'(blocked), 32'h0);

    // random soak
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      idle();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        pl_valid[k] = ($urandom_range(0, 3) != 0);
        rd[k]       = 5'($urandom_range(0, 9));
        for (int s = 0; s < 2; s++)
          if ($urandom_range(0, 1) == 1) reg_req[k][$urandom_range(0, 10)] = 1'b1;
        mem_op[k]   = ($urandom_range(0, 3) == 0);
        blocking[k] = ($urandom_range(0, 15) == 0);
        gnt[k]      = ($urandom_range(0, 3) != 0);
      end
      for (int n = 0; n < 2; n++) begin
        wb_valid[n] = ($urandom_range(0, 1) == 1);
        wb_rd[n]    = 5'($urandom_range(0, 10));
      end
      mem_done = ($urandom_range(0, 3) == 0);
      blk_done = ($urandom_range(0, 7) == 0);
      commit();
    end

    @(negedge clk); idle();
    #4;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Sequential, multi-channel successor to the combinational register grant checker.
- Holds the register lock vector internally. Locks are set when an instruction is granted and cleared on writeback.
- Tracks memory-busy and blocking (serialising) state across cycles.
- Produces in-order per-channel arbitration requests for the issue stage of the maverickOne pipeline.

Parameters:
- NR, 32, number of architectural registers; x0 is never locked.
- NCH, 2, issue channels; channel 0 is oldest in program order.
- NWB, 2, writeback ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- pl_valid_i  in  NCH  per-channel instruction valid
- blocking_i  in  NCH  per-channel serialising instruction
- rd_i  in  NCH x $clog2(NR)  per-channel destination index
- reg_req_i  in  NCH x NR  per-channel source register mask
- mem_op_i  in  NCH  per-channel memory operation
- gnt_i  in  NCH  grant from external arbiter
- wb_valid_i  in  NWB  writeback valid
- wb_rd_i  in  NWB x $clog2(NR)  writeback register index
- mem_done_i  in  1  outstanding memory op completed
- blk_done_i  in  1  blocking instruction retired
- arb_req_o  out  NCH  channel may issue this cycle
- locks_o  out  NR  registered lock vector
- mem_busy_o  out  1  registered memory-busy flag
- blocked_o  out  1  FSM in BLOCKED

Behaviour:
- Reset: locks_q=0, mem_busy_q=0, FSM=RUN. Outputs follow: arb_req_o=0, locks_o=0, mem_busy_o=0, blocked_o=0. Reset overrides every same-cycle event and aborts any in-flight block.
- FSM has two states:
  - RUN to BLOCKED on a qualified grant of a blocking instruction.
  - BLOCKED to RUN on blk_done_i.
  - blk_done_i in RUN is ignored.
  - In BLOCKED, all arb_req_o=0 and locks_o is all-ones except bit 0.
- arb_req_o[k] is combinational and requires all of:
  - FSM=RUN and pl_valid_i[k].
  - (reg_req_i[k] & locks_q) == 0, with bit 0 of reg_req_i ignored.
  - rd_i[k] not locked (WAW), or rd_i[k]==0.
  - Not (mem_op_i[k] & mem_busy_q).
  - For k>0: arb_req_o[k-1]=1, which enforces in-order issue.
  - For k>0: reg_req_i[k] and rd_i[k] do not overlap any nonzero rd_i[j] for j<k.
  - For k>0: not both mem_op_i[k] and any mem_op_i[j] for j<k.
  - If blocking_i[k]: k==0 and locks_q==0 and mem_busy_q==0. A blocking instruction on k>0 never requests.
- A grant is qualified only when gnt_i[k] & arb_req_o[k]. An unqualified gnt_i is ignored.
- Lock update each cycle: locks_d = (locks_q & ~clr) | set.
  - set = onehot(rd_i[k]) for each qualified grant with rd≠0.
  - clr = onehot(wb_rd_i[n]) for each wb_valid_i[n] with wb_rd≠0.
  - Set wins over clear on the same register in the same cycle (new writer).
  - Bit 0 is forced to 0.
  - Writeback to an unlocked register is a no-op.
- Latency: a lock set or cleared in cycle t is visible on locks_o and in arbitration at t+1. There is no same-cycle writeback bypass.
- Memory busy: mem_busy_d = (mem_busy_q & ~mem_done_i) | qualified mem grant. A new grant together with mem_done_i in the same cycle leaves the flag at 1.
- Blocking grant in cycle t: blocked_o=1 from t+1. The blocking instruction's own rd lock is still recorded. Writebacks continue to clear locks_q during BLOCKED. The forced-all-ones view applies only to locks_o.

Decomposition:
- maverickOne_pkg gains: NUM_ISSUE_CH (=NCH default), NUM_WB_PORTS, and typedef sb_state_e {SB_RUN, SB_BLOCKED}. NUM_REGS already exists and feeds NR.
- One sub-module, sb_chan_ckr: per-channel combinational hazard check (locks, intra-bundle overlap, mem, blocking). It is instantiated NCH times inside a generate loop, chained via the previous channel's request.

Test Plan:
- Reset mid-BLOCKED with locks_q=0x0000_00F0 → next cycle locks_o=0, blocked_o=0, mem_busy_o=0, FSM=RUN.
- Ch0 rd=5 granted at t; ch0 at t+1 has reg_req=1<<5 → arb_req_o[0]=0 until wb_rd=5 at t+2; arb_req_o[0]=1 at t+3.
- Same cycle: gnt ch0 rd=7 and wb_rd=7 → locks_o[7]=1 next cycle (set wins).
- Ch0 rd=3, ch1 reg_req=1<<3, both valid, no locks → arb_req_o=2'b01. Ch1 with independent regs → 2'b11. Ch1 with ch0 pl_valid=0 → 2'b00.
- mem_busy_q=1, ch0 mem_op → arb_req_o[0]=0. mem_done_i together with a new mem grant → mem_busy_o stays 1.
- Blocking ch0 with locks_q≠0 → no request. After all writebacks drain, request and grant → blocked_o=1, locks_o=0xFFFF_FFFE, arb_req_o=0. blk_done_i → RUN next cycle. Random soak of 1000 cycles checks that no qualified grant ever hits a locked source.
